// File: rtl/trena_pkg.sv
// trena_pkg: state codes, ASCII constants, last-index constants and BCD-to-ASCII helper for the TRENA TX sequencer.
package trena_pkg;

    localparam logic [2:0] ST_INICIAL = 3'd0;
    localparam logic [2:0] ST_CARREGA = 3'd1;
    localparam logic [2:0] ST_ENVIA   = 3'd2;
    localparam logic [2:0] ST_ESPERA  = 3'd3;
    localparam logic [2:0] ST_PROXIMO = 3'd4;
    localparam logic [2:0] ST_FINAL   = 3'd5;

    localparam logic [6:0] ASC_ZERO  = 7'h30;
    localparam logic [6:0] ASC_HASH  = 7'h23;
    localparam logic [6:0] ASC_QMARK = 7'h3F;
    localparam logic [6:0] ASC_CR    = 7'h0D;
    localparam logic [6:0] ASC_LF    = 7'h0A;

    localparam logic [2:0] LAST_IDX_STD  = 3'd3;
    localparam logic [2:0] LAST_IDX_CRLF = 3'd5;

    function automatic logic [6:0] bcd_to_ascii(input logic [3:0] d);
        return (d > 4'd9) ? ASC_QMARK : ASC_ZERO + {3'b000, d};
    endfunction

endpackage

// File: rtl/trena_tx_char.sv
// trena_tx_char: maps a frame index and three BCD digits to the ASCII character to send.
// TRENA_TX_CRLF_EN appends CR (index 4) and LF (index 5) after '#'.
module trena_tx_char
    import trena_pkg::*;
(
    input  logic [2:0]  i_idx,
    input  logic [11:0] i_bcd,
    output logic [6:0]  o_char
);

    assign o_char = (i_idx == 3'd0) ? bcd_to_ascii(i_bcd[11:8]) :
                    (i_idx == 3'd1) ? bcd_to_ascii(i_bcd[7:4])  :
                    (i_idx == 3'd2) ? bcd_to_ascii(i_bcd[3:0])  :
`ifdef TRENA_TX_CRLF_EN
                    (i_idx == 3'd4) ? ASC_CR :
                    (i_idx == 3'd5) ? ASC_LF :
`endif
                    ASC_HASH;

endmodule

// File: rtl/trena_tx_seq.sv
// trena_tx_seq: sends one BCD measurement frame ("hhh#" or, with TRENA_TX_CRLF_EN, "hhh#\r\n")
// to a serial transmitter using a start/done handshake.
module trena_tx_seq
    import trena_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        iniciar,
    input  logic [11:0] medida,
    input  logic        tx_pronto,
    output logic        tx_partida,
    output logic [6:0]  tx_dado,
    output logic        ocupado,
    output logic        fim,
    output logic [3:0]  db_estado
);

`ifdef TRENA_TX_CRLF_EN
    localparam logic [2:0] LAST_IDX = LAST_IDX_CRLF;
`else
    localparam logic [2:0] LAST_IDX = LAST_IDX_STD;
`endif

    logic [2:0]  r_estado;
    logic [2:0]  r_idx;
    logic [11:0] r_medida;
    logic [6:0]  r_dado;
    logic [2:0]  w_prox;
    logic [2:0]  w_sel_idx;
    logic [11:0] w_sel_bcd;
    logic [6:0]  w_char;
    logic        w_load;

    always_comb begin
        w_prox = ST_INICIAL;
        case (r_estado)
            ST_INICIAL: w_prox = iniciar ? ST_CARREGA : ST_INICIAL;
            ST_CARREGA: w_prox = ST_ENVIA;
            ST_ENVIA:   w_prox = ST_ESPERA;
            ST_ESPERA:  w_prox = !tx_pronto ? ST_ESPERA : (r_idx == LAST_IDX) ? ST_FINAL : ST_PROXIMO;
            ST_PROXIMO: w_prox = ST_ENVIA;
            default:    w_prox = ST_INICIAL;
        endcase
    end

    // The character is computed one cycle ahead so tx_dado is already valid in ENVIA.
    assign w_load    = (r_estado == ST_CARREGA) || (r_estado == ST_PROXIMO);
    assign w_sel_idx = (r_estado == ST_CARREGA) ? 3'd0 : r_idx + 3'd1;
    assign w_sel_bcd = (r_estado == ST_CARREGA) ? medida : r_medida;

    trena_tx_char u_char (
        .i_idx  (w_sel_idx),
        .i_bcd  (w_sel_bcd),
        .o_char (w_char)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_estado <= ST_INICIAL;
            r_idx    <= 3'd0;
            r_medida <= 12'h000;
            r_dado   <= 7'h00;
        end else begin
            r_estado <= w_prox;
            if (r_estado == ST_CARREGA) begin
                r_medida <= medida;
                r_idx    <= 3'd0;
            end
            if (r_estado == ST_PROXIMO)
                r_idx <= r_idx + 3'd1;
            if (w_load)
                r_dado <= w_char;
        end
    end

    assign tx_partida = (r_estado == ST_ENVIA);
    assign fim        = (r_estado == ST_FINAL);
    assign ocupado    = (r_estado != ST_INICIAL);
    assign tx_dado    = r_dado;
    assign db_estado  = (r_estado > ST_FINAL) ? 4'hF : {1'b0, r_estado};

endmodule

// File: tb/tb_trena_tx_seq.sv
// tb_trena_tx_seq: randomized self-checking bench for trena_tx_seq with a frame-level reference model.
module tb_trena_tx_seq;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        iniciar = 1'b0;
    logic [11:0] medida = 12'h000;
    logic        tx_pronto = 1'b0;
    logic        tx_partida;
    logic [6:0]  tx_dado;
    logic        ocupado;
    logic        fim;
    logic [3:0]  db_estado;

    int errors = 0;
    int checks = 0;

`ifdef TRENA_TX_CRLF_EN
    localparam int FRAME_LEN = 6;
`else
    localparam int FRAME_LEN = 4;
`endif

    trena_tx_seq dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .iniciar    (iniciar),
        .medida     (medida),
        .tx_pronto  (tx_pronto),
        .tx_partida (tx_partida),
        .tx_dado    (tx_dado),
        .ocupado    (ocupado),
        .fim        (fim),
        .db_estado  (db_estado)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] exp_char(input logic [11:0] m, input int i);
        int d;
        if (i < 3) begin
            d = int'((m >> (4 * (2 - i))) & 12'hF);
            return (d > 9) ? 7'h3F : 7'(48 + d);
        end
        return (i == 3) ? 7'h23 : (i == 4) ? 7'h0D : 7'h0A;
    endfunction

    // Drives one full frame as the serial transmitter would and checks every character.
    task automatic run_frame(input logic [11:0] m, input int gap, input bit hold, input bit cont,
                             input logic [11:0] m_mid, input int glitch);
        logic [6:0] want;
        int t;
        if (!cont) begin
            @(negedge clock);
            iniciar = 1'b1;
            medida  = m;
        end
        @(negedge clock);
        iniciar = hold;
        checks++;
        if (db_estado !== 4'd1) $display("FAIL carrega: db_estado=%0h want 1", db_estado);
        if (db_estado !== 4'd1) errors++;
        for (int i = 0; i < FRAME_LEN; i++) begin
            want = exp_char(m, i);
            t = 0;
            do begin
                @(negedge clock);
                t++;
            end while (!tx_partida && t < 20);
            checks++;
            if (tx_partida !== 1'b1 || t != 1) begin
                errors++;
                $display("FAIL start[%0d]: tx_partida=%b after %0d cycles want 1 after 1", i, tx_partida, t);
                if (t >= 20) return;
            end
            checks++;
            if (tx_dado !== want) begin
                errors++;
                $display("FAIL char[%0d] m=%h: tx_dado=%h want %h", i, m, tx_dado, want);
            end
            if (i == 1) medida = m_mid;
            if (i == glitch) tx_pronto = 1'b1;
            for (int g = 0; g < gap; g++) begin
                @(negedge clock);
                tx_pronto = 1'b0;
                checks++;
                if (db_estado !== 4'd3 || tx_partida !== 1'b0 || tx_dado !== want) begin
                    errors++;
                    $display("FAIL espera[%0d]: db=%0h partida=%b dado=%h want 3 0 %h", i, db_estado, tx_partida, tx_dado, want);
                end
            end
            tx_pronto = 1'b1;
            @(negedge clock);
            tx_pronto = 1'b0;
            checks++;
            if (fim !== (i == FRAME_LEN - 1) || db_estado !== ((i == FRAME_LEN - 1) ? 4'd5 : 4'd4)) begin
                errors++;
                $display("FAIL after_pronto[%0d]: fim=%b db=%0h", i, fim, db_estado);
            end
        end
        @(negedge clock);
        checks++;
        if (ocupado !== 1'b0 || fim !== 1'b0 || db_estado !== 4'd0) begin
            errors++;
            $display("FAIL idle: ocupado=%b fim=%b db=%0h want 0 0 0", ocupado, fim, db_estado);
        end
    endtask

    task automatic test_reset();
        #3 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        checks++;
        if (db_estado !== 4'd0 || ocupado !== 1'b0 || tx_partida !== 1'b0 || fim !== 1'b0 || tx_dado !== 7'h00) begin
            errors++;
            $display("FAIL reset: db=%0h ocupado=%b partida=%b fim=%b dado=%h want all 0", db_estado, ocupado, tx_partida, fim, tx_dado);
        end
    endtask

    task automatic test_spurious_idle();
        @(negedge clock);
        tx_pronto = 1'b1;
        @(negedge clock);
        tx_pronto = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (db_estado !== 4'd0 || tx_partida !== 1'b0 || ocupado !== 1'b0) begin
                errors++;
                $display("FAIL spurious_idle: db=%0h partida=%b ocupado=%b want 0 0 0", db_estado, tx_partida, ocupado);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_basic();
        run_frame(12'h123, 5, 1'b0, 1'b0, 12'h123, -1);
        run_frame(12'h0A5, 5, 1'b0, 1'b0, 12'h0A5, -1);
`ifdef TRENA_TX_CRLF_EN
        run_frame(12'h999, 5, 1'b0, 1'b0, 12'h999, -1);
`endif
    endtask

    task automatic test_back_to_back();
        run_frame(12'h321, 3, 1'b1, 1'b0, 12'h456, -1);
        run_frame(12'h456, 2, 1'b0, 1'b1, 12'h456, -1);
    endtask

    task automatic test_spurious_envia();
        run_frame(12'h807, 2, 1'b0, 1'b0, 12'h807, 0);
        run_frame(12'hF4C, 1, 1'b0, 1'b0, 12'hF4C, 2);
    endtask

    task automatic test_reset_midframe();
        @(negedge clock);
        iniciar = 1'b1;
        medida  = 12'h777;
        @(negedge clock);
        iniciar = 1'b0;
        @(negedge clock);
        @(negedge clock);
        tx_pronto = 1'b1;
        @(negedge clock);
        tx_pronto = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (db_estado !== 4'd3) begin
            errors++;
            $display("FAIL mid_espera: db=%0h want 3", db_estado);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (ocupado !== 1'b0 || tx_partida !== 1'b0 || db_estado !== 4'd0 || tx_dado !== 7'h00 || fim !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: ocupado=%b partida=%b db=%0h dado=%h fim=%b want 0", ocupado, tx_partida, db_estado, tx_dado, fim);
        end
        @(negedge clock);
        reset_n = 1'b1;
        tx_pronto = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            tx_pronto = 1'b0;
            checks++;
            if (db_estado !== 4'd0 || tx_partida !== 1'b0) begin
                errors++;
                $display("FAIL no_resume: db=%0h partida=%b want 0 0", db_estado, tx_partida);
            end
        end
        run_frame(12'h250, 3, 1'b0, 1'b0, 12'h250, -1);
    endtask

    task automatic test_random();
        logic [11:0] m;
        for (int n = 0; n < 8; n++) begin
            m = 12'($urandom);
            run_frame(m, int'($urandom_range(1, 6)), 1'b0, 1'b0, 12'($urandom), -1);
        end
    endtask

    initial begin
        test_reset();
        test_spurious_idle();
        test_basic();
        test_back_to_back();
        test_spurious_envia();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trena_tx_seq.md
TRENA_TX_SEQ -- requirements
Module: trena_tx_seq

Interface
REQ-001 The block SHALL have port clock, input, 1 bit: single rising-edge system clock.
REQ-002 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port iniciar, input, 1 bit: request to transmit one measurement frame.
REQ-004 The block SHALL have port medida, input, 12 bits: three BCD digits, hundreds[11:8], tens[7:4], units[3:0].
REQ-005 The block SHALL have port tx_pronto, input, 1 bit: one-cycle pulse from the serial transmitter signalling that the character has been sent.
REQ-006 The block SHALL have port tx_partida, output, 1 bit: one-cycle start pulse to the serial transmitter.
REQ-007 The block SHALL have port tx_dado, output, 7 bits: ASCII character to be sent.
REQ-008 The block SHALL have port ocupado, output, 1 bit: high in every state except INICIAL.
REQ-009 The block SHALL have port fim, output, 1 bit: one-cycle pulse when the frame is complete.
REQ-010 The block SHALL have port db_estado, output, 4 bits: current state code for debug.

Function
REQ-011 The state machine SHALL have these states and codes: INICIAL=0, CARREGA=1, ENVIA=2, ESPERA=3, PROXIMO=4, FINAL=5; any other code SHALL go to INICIAL and show db_estado=4'hF.
REQ-012 In INICIAL, iniciar=1 SHALL move the block to CARREGA; iniciar=0 SHALL keep it in INICIAL.
REQ-013 In CARREGA, medida SHALL be registered, the character index SHALL be cleared to 0, and the next state SHALL be ENVIA.
REQ-014 ENVIA SHALL assert tx_partida for exactly one cycle and then go to ESPERA.
REQ-015 ESPERA SHALL hold until tx_pronto=1; the next state SHALL then be FINAL if the index equals the last index, otherwise PROXIMO.
REQ-016 PROXIMO SHALL increment the index and go to ENVIA.
REQ-017 FINAL SHALL assert fim for one cycle and then go to INICIAL.
REQ-018 The frame SHALL be, by index: 0 = hundreds, 1 = tens, 2 = units, 3 = '#' (7'h23); the last index SHALL be 3.
REQ-019 Each digit character SHALL be 7'h30 + digit; a BCD digit greater than 9 SHALL be sent as '?' (7'h3F).
REQ-020 tx_dado SHALL be registered, valid from the ENVIA cycle, and stable through ESPERA; otherwise it SHALL hold its last value.
REQ-021 Latency from the iniciar sample to the first tx_partida SHALL be 2 cycles.
REQ-022 iniciar outside INICIAL SHALL be ignored; a later change to medida SHALL not affect the frame in progress.
REQ-023 tx_pronto outside ESPERA SHALL be ignored.
REQ-024 If tx_pronto arrives in the same cycle the block enters ESPERA, it SHALL not be accepted until the next cycle.
REQ-025 The index SHALL be 3 bits wide and SHALL never wrap during a frame.

Reset
REQ-026 reset_n=0 SHALL, at any time including mid-frame, force INICIAL, index=0, registered medida=0, tx_dado=7'h00, tx_partida=0, fim=0, ocupado=0 and db_estado=0.
REQ-027 After reset_n is released, the block SHALL take no action until a new iniciar; no partial frame SHALL be resumed.

Configuration
REQ-028 The macro TRENA_TX_CRLF_EN SHALL control the frame terminator: when defined, index 4 SHALL send CR (7'h0D) and index 5 LF (7'h0A), and the last index SHALL be 5.
REQ-029 When TRENA_TX_CRLF_EN is undefined, the frame SHALL end at '#' with last index 3, and no CR/LF logic SHALL exist.

Structure
REQ-030 The package trena_pkg SHALL hold the state encodings, the ASCII constants ('0', '#', '?', CR, LF) and the last-index constants.
REQ-031 Character selection (index plus registered BCD to ASCII) SHALL be a sub-module named trena_tx_char; everything else SHALL stay in trena_tx_seq.

Verification
REQ-032 medida=12'h123, iniciar pulse, tx_pronto returned 5 cycles after each tx_partida -> the block SHALL send 7'h31, 7'h32, 7'h33, 7'h23, then pulse fim once.
REQ-033 medida=12'h0A5 -> the block SHALL send 7'h30, 7'h3F, 7'h35, 7'h23.
REQ-034 With TRENA_TX_CRLF_EN defined and medida=12'h999 -> the block SHALL send 39, 39, 39, 23, 0D, 0A (hex), with fim after the 6th tx_pronto.
REQ-035 iniciar held high and medida changed to 12'h456 during a frame for 12'h321 -> the frame SHALL send only "321#", followed by a new frame "456#".
REQ-036 reset_n pulled low during ESPERA of index 1 -> within the same cycle the block SHALL show ocupado=0 and tx_partida=0, and db_estado SHALL be 0.
REQ-037 A spurious tx_pronto in INICIAL and in ENVIA -> there SHALL be no state change or extra character.
